// File: rtl/bm13xx_tx_arbiter.sv
// bm13xx_tx_arbiter: frame-level arbiter sharing the BM13xx UART TX between command and work byte streams.
module bm13xx_tx_arbiter #(
  parameter int GAP_CYCLES     = 32,
  parameter int CMD_MAX_CONSEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  input  logic       cmd_last,
  output logic       cmd_ready,
  input  logic [7:0] work_data,
  input  logic       work_valid,
  input  logic       work_last,
  output logic       work_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_src
);
  typedef enum logic [1:0] {IDLE, CMD, WORK, GAP} state_t;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state;
  logic [GW-1:0] gap_cnt;
  logic [3:0] cmd_streak;
  logic sel_last, last_acc, cmd_win;
  always_comb begin
    tx_valid = state == CMD ? cmd_valid : state == WORK ? work_valid : 1'b0;
    tx_data = state == CMD ? cmd_data : state == WORK ? work_data : 8'h00;
    cmd_ready = state == CMD && tx_ready;
    work_ready = state == WORK && tx_ready;
    sel_last = state == CMD ? cmd_last : work_last;
    last_acc = tx_valid && sel_last && tx_ready;
    cmd_win = cmd_valid && (!work_valid || cmd_streak < 4'(CMD_MAX_CONSEC));
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gap_cnt <= '0;
      cmd_streak <= 4'd0;
      frame_done <= 1'b0;
      frame_src <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (enable && (cmd_valid || work_valid)) state <= cmd_win ? CMD : WORK;
        CMD, WORK: if (last_acc) begin
          state <= GAP_CYCLES > 0 ? GAP : IDLE;
          gap_cnt <= GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
          frame_done <= 1'b1;
          frame_src <= state == WORK;
          // a command streak only matters while work is actually waiting
          cmd_streak <= (state == WORK || !work_valid) ? 4'd0 :
                        cmd_streak == 4'hf ? cmd_streak : cmd_streak + 4'd1;
        end
        GAP: if (gap_cnt == '0) state <= IDLE; else gap_cnt <= gap_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bm13xx_tx_arbiter.sv
// tb_bm13xx_tx_arbiter: queue scoreboard plus frame-level reference model for bm13xx_tx_arbiter.
module tb_bm13xx_tx_arbiter;
  localparam int G = 32, MAXC = 4;
  typedef logic [8:0] ent_t;
  logic clk = 0, rst = 1, enable, tx_ready;
  logic [7:0] cmd_data = 0, work_data = 0, tx_data;
  logic cmd_valid = 0, cmd_last = 0, work_valid = 0, work_last = 0;
  logic cmd_ready, work_ready, tx_valid, busy, frame_done, frame_src;
  logic [7:0] z8 = 0, w0_data = 0, t0_data;
  logic z1 = 0, e1 = 1, w0_valid = 0, w0_last = 0;
  logic c0_ready, w0_ready, t0_valid, b0_busy, f0_done, f0_src;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, gap_end = 0, last_cyc = -100, streak = 0, acc_cnt = 0, grant_cnt = 0;
  bit mon_on = 0, in_frame = 0, pend = 0, owner = 0, choice = 0, done_src = 0;
  bit en_rand = 0, en_target = 1, gaps = 0;
  int tr_mode = 0;
  ent_t cq[$], wq[$];
  ent_t mon_e;
  bit glog[$];
  bit starve_exp[7] = '{0, 0, 0, 0, 1, 0, 0};

  bm13xx_tx_arbiter #(.GAP_CYCLES(G), .CMD_MAX_CONSEC(MAXC)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
    .work_data(work_data), .work_valid(work_valid), .work_last(work_last), .work_ready(work_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .frame_src(frame_src));

  bm13xx_tx_arbiter #(.GAP_CYCLES(0), .CMD_MAX_CONSEC(MAXC)) dut0 (
    .clk(clk), .rst(rst), .enable(e1),
    .cmd_data(z8), .cmd_valid(z1), .cmd_last(z1), .cmd_ready(c0_ready),
    .work_data(w0_data), .work_valid(w0_valid), .work_last(w0_last), .work_ready(w0_ready),
    .tx_data(t0_data), .tx_valid(t0_valid), .tx_ready(e1),
    .busy(b0_busy), .frame_done(f0_done), .frame_src(f0_src));

  always #5 clk = ~clk;

  initial begin
    tx_ready = 1;
    enable = 1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? ($urandom_range(0, 9) < 7) : ~tx_ready;
      enable = en_rand ? ($urandom_range(0, 9) != 0) : en_target;
    end
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame ownership, byte order, gap timing and starvation bound.
  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (pend) begin
        pend = 0;
        in_frame = 1;
        owner = choice;
        grant_cnt++;
        glog.push_back(choice);
        chk("grant_tx_valid", tx_valid, 1);
        if (owner ? wq.size() == 0 : cq.size() == 0) chk("grant_queue_empty", 0, 1);
        else chk("grant_first_byte", tx_data, owner ? wq[0][7:0] : cq[0][7:0]);
      end
      chk("busy", busy, in_frame || cyc < gap_end);
      chk("frame_done", frame_done, cyc == last_cyc + 1);
      if (cyc == last_cyc + 1) chk("frame_src", frame_src, done_src);
      if (in_frame) begin
        chk("tx_valid_follow", tx_valid, owner ? work_valid : cmd_valid);
        chk("owner_ready", owner ? work_ready : cmd_ready, tx_ready);
        chk("other_ready", owner ? cmd_ready : work_ready, 0);
        if (tx_valid && tx_ready) begin
          if (owner ? wq.size() == 0 : cq.size() == 0) chk("accept_queue_empty", 0, 1);
          else begin
            mon_e = owner ? wq.pop_front() : cq.pop_front();
            chk("tx_data", tx_data, mon_e[7:0]);
            acc_cnt++;
            if (mon_e[8]) begin
              in_frame = 0;
              last_cyc = cyc;
              gap_end = cyc + G + 1;
              done_src = owner;
              streak = (owner || !work_valid) ? 0 : (streak < 15 ? streak + 1 : 15);
            end
          end
        end
      end else begin
        chk("idle_tx_valid", tx_valid, 0);
        chk("idle_tx_data", tx_data, 0);
        chk("idle_readies", {cmd_ready, work_ready}, 0);
        if (cyc >= gap_end && enable && (cmd_valid || work_valid)) begin
          pend = 1;
          choice = !(cmd_valid && (!work_valid || streak < MAXC));
        end
      end
    end
  end

  task automatic send_byte(input bit src, input logic [7:0] d, input bit l);
    int n;
    bit acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    if (src) begin
      work_data = d; work_last = l; work_valid = 1; wq.push_back({l, d});
    end else begin
      cmd_data = d; cmd_last = l; cmd_valid = 1; cq.push_back({l, d});
    end
    n = 0;
    acc = 0;
    while (!acc && n < 4000) begin
      @(negedge clk);
      acc = src ? work_ready : cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk(src ? "work_accept_timeout" : "cmd_accept_timeout", 0, 1);
    if (src) begin work_valid = 0; work_last = 0; end
    else begin cmd_valid = 0; cmd_last = 0; end
  endtask

  task automatic send_frame(input bit src, input int len);
    for (int i = 0; i < len; i++) send_byte(src, 8'($urandom), i == len - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((cq.size() > 0 || wq.size() > 0 || in_frame || pend || cyc < gap_end + 2) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 5000) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_acc(input int k);
    int b = acc_cnt;
    int n = 0;
    while (acc_cnt < b + k && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 500) chk("wait_accept_timeout", 0, 1);
  endtask

  initial begin
    int n, g0, b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_readies", {cmd_ready, work_ready}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_src", frame_src, 0);
    chk("rst_streak", dut.cmd_streak, 0);
    @(posedge clk);
    #1;
    rst = 0;
    mon_on = 1;
    // zero-gap instance: back-to-back single-byte work frames
    w0_valid = 1; w0_data = 8'h11; w0_last = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (t0_valid) break;
      n++;
    end
    chk("g0_first_grant", t0_valid, 1);
    chk("g0_first_byte", t0_data, 8'h11);
    @(posedge clk);
    #1;
    w0_data = 8'h22;
    @(negedge clk);
    chk("g0_idle_tx_valid", t0_valid, 0);
    chk("g0_frame_done", f0_done, 1);
    chk("g0_frame_src", f0_src, 1);
    @(negedge clk);
    chk("g0_second_rise", t0_valid, 1);
    chk("g0_second_byte", t0_data, 8'h22);
    @(posedge clk);
    #1;
    w0_valid = 0;
    // single command frame
    send_byte(0, 8'h55, 0);
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'h02, 1);
    drain();
    // starvation bound
    glog.delete();
    fork
      begin repeat (6) send_frame(0, $urandom_range(1, 3)); end
      send_frame(1, 2);
    join
    drain();
    chk("starve_grants", glog.size(), 7);
    for (int i = 0; i < 7; i++) if (i < glog.size()) chk($sformatf("starve_order_%0d", i), glog[i], starve_exp[i]);
    // backpressure on a work frame with a pending single-byte command
    tr_mode = 2;
    fork
      send_frame(1, 5);
      begin repeat (3) @(posedge clk); #1; send_byte(0, 8'($urandom), 1); end
    join
    drain();
    // enable dropped mid-frame
    tr_mode = 0;
    b0 = acc_cnt;
    fork
      send_frame(0, 4);
      begin wait_acc(2); en_target = 0; end
    join
    chk("cmd_bytes_after_disable", acc_cnt - b0, 4);
    g0 = grant_cnt;
    fork
      send_frame(1, 3);
      begin repeat (G + 60) @(posedge clk); #1; chk("no_grant_while_disabled", grant_cnt, g0); en_target = 1; end
    join
    drain();
    // randomized mix
    tr_mode = 1;
    en_rand = 1;
    gaps = 1;
    fork
      begin repeat (14) send_frame(0, $urandom_range(1, 6)); end
      begin repeat (8) send_frame(1, $urandom_range(1, 6)); end
    join
    en_rand = 0;
    drain();
    // reset during byte 2 of a command frame
    tr_mode = 0;
    gaps = 0;
    send_byte(0, 8'h3C, 0);
    mon_on = 0;
    cmd_data = 8'hC3; cmd_last = 0; cmd_valid = 1; rst = 1;
    @(negedge clk);
    chk("pre_reset_byte2", tx_data, 8'hC3);
    @(posedge clk);
    #1;
    rst = 0;
    cmd_valid = 0;
    @(negedge clk);
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_frame_done", frame_done, 0);
    chk("post_rst_streak", dut.cmd_streak, 0);
    cq.delete(); wq.delete();
    in_frame = 0; pend = 0; streak = 0; gap_end = 0; last_cyc = -100;
    mon_on = 1;
    @(posedge clk);
    #1;
    send_frame(1, 3);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog timeout");
  end
endmodule

// File: doc/bm13xx_tx_arbiter.md
Name: bm13xx_tx_arbiter

Overview:
- Shares the single BM13xx UART transmitter between two frame-oriented byte streams: command frames (register R/W, chain config) and work frames (mining jobs).
- Sits between the command/work TX FIFOs and the UART TX serializer (3.125 Mbaud) inside axi_bm13xx.
- Arbitrates only at frame boundaries; a granted frame owns the serializer until its last byte.
- Enforces a minimum inter-frame idle gap and bounds work starvation under command bursts.

Parameters:
- GAP_CYCLES, 32, idle clk cycles inserted after each frame's last byte is accepted; 0 = no gap state.
- CMD_MAX_CONSEC, 4, max consecutive command frames granted while work_valid is pending; range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  arbitration enable; gates new grants only.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  command byte valid.
- cmd_last  in  1  marks the final byte of a command frame.
- cmd_ready  out  1  command byte accepted when cmd_valid & cmd_ready.
- work_data  in  8  work byte.
- work_valid  in  1  work byte valid.
- work_last  in  1  marks the final byte of a work frame.
- work_ready  out  1  work byte accepted when work_valid & work_ready.
- tx_data  out  8  byte to the serializer.
- tx_valid  out  1  byte valid to the serializer.
- tx_ready  in  1  serializer ready.
- busy  out  1  high in CMD, WORK or GAP.
- frame_done  out  1  one-cycle pulse after a frame's last byte is accepted.
- frame_src  out  1  source of the finished frame: 0 = cmd, 1 = work; valid with frame_done.

Behaviour:
- Handshake: valid/ready. A byte transfers on a cycle where valid & ready. Source data must remain stable while valid is high and not accepted.
- States: IDLE, CMD, WORK, GAP. Reset state is IDLE.
- Reset values: all ready, tx_valid, busy and frame_done = 0; tx_data = 0; frame_src = 0; cmd_streak = 0; gap counter = 0.
- IDLE:
  - No grant while enable = 0.
  - Go to CMD if enable & cmd_valid & (!work_valid | cmd_streak < CMD_MAX_CONSEC).
  - Otherwise go to WORK if enable & work_valid.
  - Otherwise stay in IDLE.
  - The grant decision is registered, so tx_valid first rises one cycle after the request is seen.
- CMD (combinational pass-through):
  - tx_data = cmd_data, tx_valid = cmd_valid, cmd_ready = tx_ready.
  - work_ready = 0.
- WORK: mirror image of CMD; cmd_ready = 0.
- In IDLE and GAP: tx_data = 0 and tx_valid = 0.
- Frame end:
  - When the last byte is accepted (selected valid & last & tx_ready), go to GAP if GAP_CYCLES > 0, else to IDLE.
  - frame_done is registered high for exactly the next cycle; frame_src is registered with it.
- GAP:
  - The counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - Leave to IDLE on the cycle the counter is 0, so GAP lasts exactly GAP_CYCLES cycles.
  - Earliest next tx_valid: last-accept cycle + GAP_CYCLES + 2.
- cmd_streak (4-bit):
  - Increments on completion of a command frame, saturating at 15.
  - Clears to 0 on completion of a work frame.
  - Also clears to 0 when a command frame completes while work_valid = 0.
- Boundary conditions:
  - enable dropping mid-frame: the current frame completes, then the gap runs; no new grant until enable = 1.
  - cmd and work both valid in IDLE with cmd_streak < CMD_MAX_CONSEC: cmd wins.
  - Both valid with cmd_streak = CMD_MAX_CONSEC: work wins.
  - Single-byte frame (valid & last on the first byte) is legal.
  - Valid gaps inside a frame: ownership is held, tx_valid follows the source.
  - tx_ready held low: no byte is lost, the source stalls.
  - Reset mid-frame: the frame is abandoned and all outputs return to reset values on the next cycle; the partial frame is not replayed.
  - The non-granted source's last flag is ignored.

Test Plan:
- Single cmd frame 0x55,0xAA,0x02 (last), tx_ready = 1, GAP_CYCLES = 32:
  - tx_valid is high for 3 cycles starting the cycle after cmd_valid, bytes in order.
  - frame_done = 1, frame_src = 0 one cycle after the last byte.
  - busy stays high 32 more cycles.
- Starvation bound, CMD_MAX_CONSEC = 4: 6 queued cmd frames plus 1 work frame all valid.
  - Required grant order: C,C,C,C,W,C,C.
- Backpressure: tx_ready toggled 1/0 every cycle during a 5-byte work frame.
  - All 5 bytes appear on tx_data exactly once, in order.
  - cmd_ready stays 0 even though cmd_valid = 1 throughout.
- enable is dropped after byte 2 of a 4-byte cmd frame.
  - Bytes 3–4 are still sent.
  - With enable held 0, no new grant occurs after the gap while work_valid = 1.
- rst asserted for 1 cycle during byte 2 of a cmd frame.
  - Next cycle: state IDLE, tx_valid = 0, cmd_ready = 0, cmd_streak = 0.
  - A fresh work frame is then granted normally.
- GAP_CYCLES = 0: two back-to-back single-byte work frames.
  - The second tx_valid rises exactly 2 cycles after the first byte is accepted (1 cycle in IDLE).
